// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction-memory fetch handshake between sequencer and IM
interface fetch_sequencer_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and IM fetch/issue sequencer; optional NPC_ALIGN_CHECK_EN adds a sticky trap on bad npc
module fetch_sequencer #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_DEPTH = 4096
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_stall,
    input  logic [31:0]                i_npc,
    fetch_sequencer_if.master          im,
    output logic [31:0]                o_instr_out,
    output logic                       o_instr_valid,
    output logic [31:0]                o_pc,
    output logic [31:0]                o_pc4,
    output logic [31:0]                o_retired,
    output logic                       o_pc_fault
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_ISSUE = 2'd1,
        S_TRAP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retired;
    logic        w_req;
    logic        w_valid;
    logic        w_capture;
    logic        w_accept;
    logic        w_load_pc;
    logic [31:0] w_npc_next;

`ifdef NPC_ALIGN_CHECK_EN
    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + 33'(4 * IM_DEPTH);
    logic w_npc_bad;

    assign w_npc_bad  = (i_npc[1:0] != 2'b00) || (i_npc < IM_BASE)
                     || ({1'b0, i_npc} >= IM_END);
    assign w_npc_next = i_npc;
    assign o_pc_fault = (r_state == S_TRAP);
`else
    // Word alignment is enforced by dropping the low bits rather than trapping.
    assign w_npc_next = i_npc & ~32'h3;
    assign o_pc_fault = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_FETCH;
            r_pc      <= PC_RESET;
            r_instr   <= 32'h0;
            r_retired <= 32'h0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_instr <= im.rdata;
            end
            if (w_accept) begin
                r_retired <= r_retired + 32'h1;
            end
            if (w_load_pc) begin
                r_pc <= w_npc_next;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_req        = 1'b0;
        w_valid      = 1'b0;
        w_capture    = 1'b0;
        w_accept     = 1'b0;
        w_load_pc    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_req = 1'b1;
                if (im.ack) begin
                    w_capture    = 1'b1;
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_valid = 1'b1;
                if (!i_stall) begin
                    w_accept = 1'b1;
`ifdef NPC_ALIGN_CHECK_EN
                    if (w_npc_bad) begin
                        w_next_state = S_TRAP;
                    end else begin
                        w_load_pc    = 1'b1;
                        w_next_state = S_FETCH;
                    end
`else
                    w_load_pc    = 1'b1;
                    w_next_state = S_FETCH;
`endif
                end
            end
            default: begin
                w_next_state = r_state;
            end
        endcase
    end

    assign im.req        = w_req;
    assign im.addr       = r_pc;
    assign o_instr_out   = r_instr;
    assign o_instr_valid = w_valid;
    assign o_pc          = r_pc;
    assign o_pc4         = r_pc + 32'h4;
    assign o_retired     = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized and directed checks of fetch_sequencer against a behavioural model
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] npc;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] retired;
    logic        pc_fault;

    fetch_sequencer_if u_if ();

    fetch_sequencer u_dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_stall       (stall),
        .i_npc         (npc),
        .im            (u_if),
        .o_instr_out   (instr_out),
        .o_instr_valid (instr_valid),
        .o_pc          (pc),
        .o_pc4         (pc4),
        .o_retired     (retired),
        .o_pc_fault    (pc_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: one instruction is either being fetched or held for decode.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_retired;
    bit          m_holding;
    bit          m_trapped;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit npc_illegal(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < 32'h3000) || (a >= 32'h3000 + 32'd16384);
    endfunction

    task automatic check_all();
        check("imem_req",    32'(u_if.req),    32'(!m_holding && !m_trapped));
        check("imem_addr",   u_if.addr,        m_pc);
        check("instr_valid", 32'(instr_valid), 32'(m_holding));
        check("instr_out",   instr_out,        m_instr);
        check("pc",          pc,               m_pc);
        check("pc4",         pc4,              m_pc + 32'd4);
        check("retired",     retired,          m_retired);
        check("pc_fault",    32'(pc_fault),    32'(m_trapped));
    endtask

    task automatic step(input bit r, input bit st, input bit ak,
                        input logic [31:0] ins, input logic [31:0] np);
        reset      = r;
        stall      = st;
        u_if.ack   = ak;
        u_if.rdata = ins;
        npc        = np;
        @(posedge clk);
        if (r) begin
            m_pc = 32'h3000; m_instr = 32'h0; m_retired = 32'h0;
            m_holding = 0; m_trapped = 0;
        end else if (m_trapped) begin
            m_trapped = 1;
        end else if (!m_holding) begin
            if (ak) begin
                m_instr   = ins;
                m_holding = 1;
            end
        end else if (!st) begin
            m_retired = m_retired + 32'd1;
            m_holding = 0;
`ifdef NPC_ALIGN_CHECK_EN
            if (npc_illegal(np)) m_trapped = 1;
            else                 m_pc = np;
`else
            m_pc = {np[31:2], 2'b00};
`endif
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [31:0] r_np;
        reset = 1'b1; stall = 1'b0; npc = 32'h0;
        u_if.ack = 1'b0; u_if.rdata = 32'h0;
        @(negedge clk);

        // Reset and same-cycle ack
        step(1, 0, 0, 32'h0, 32'h0);
        check("reset_pc", pc, 32'h3000);
        step(0, 0, 1, 32'h3402_0001, 32'h3004);
        check("issue_instr", instr_out, 32'h3402_0001);
        step(0, 0, 0, 32'h0, 32'h3004);
        check("retired_after_2", retired, 32'd1);
        check("pc_after_accept", pc, 32'h3004);

        // Delayed ack with stall ignored in FETCH
        for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h0, 32'h0);
        check("addr_steady", u_if.addr, 32'h3004);
        step(0, 1, 1, 32'hA5A5_0002, 32'h3010);

        // Hold in ISSUE under stall, then release
        for (int i = 0; i < 5; i++) step(0, 1, 0, 32'h0, 32'h3010);
        check("stall_pc_held", pc, 32'h3004);
        step(0, 0, 0, 32'h0, 32'h3040);
        check("jump_addr", u_if.addr, 32'h3040);

        // Reset mid-FETCH with ack present; late ack is dropped
        step(1, 0, 1, 32'hDEAD_BEEF, 32'h0);
        step(0, 0, 0, 32'hDEAD_BEEF, 32'h0);
        check("restart_fetch", 32'(u_if.req), 32'd1);

        // Misaligned npc
        step(0, 0, 1, 32'h1111_1111, 32'h3002);
        step(0, 0, 0, 32'h0, 32'h3002);
`ifdef NPC_ALIGN_CHECK_EN
        check("misalign_trap", 32'(pc_fault), 32'd1);
        step(0, 0, 1, 32'h0, 32'h3004);
        check("trap_no_req", 32'(u_if.req), 32'd0);
        step(1, 0, 0, 32'h0, 32'h0);
        step(0, 0, 1, 32'h0, 32'h7000);
        step(0, 0, 0, 32'h0, 32'h7000);
        check("range_trap", 32'(pc_fault), 32'd1);
`else
        check("misalign_masked", pc, 32'h3000);
`endif

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 3))
                0:       r_np = m_pc + 32'd4;
                1:       r_np = 32'h3000 + 4 * $urandom_range(0, 4095);
                2:       r_np = $urandom;
                default: r_np = 32'h3000 + $urandom_range(0, 16383);
            endcase
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 40, $urandom, r_np);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
